bbox_merge_filter: RTL
======================

// Module: bbox_merge_filter
// PURPOSE
//  Downstream of the bounding-box stage. Captures the per-label box stream that
//  stage emits after each frame and unions boxes that share a resolved parent
//  into one box per component. It then drops boxes below a runtime minimum area
//  and sends the survivors to the overlay/reporting logic over a valid/ready
//  interface. It reports a box count, a frame-done pulse, and truncation/overrun flags.
// PARAMETERS
//  WIDTH_BITS      11        x coordinate width
//  HEIGHT_BITS     10        y coordinate width
//  LABEL_WIDTH     8         label / parent width
//  NUM_LABELS      256       table depth (1<<LABEL_WIDTH)
//  COLLECT_CYCLES  258       length of capture window after frame_start (NUM_LABELS+2)
//  MAX_OUT         16        max boxes emitted per frame
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     asynchronous, active-low reset
//  frame_start  in   1     one-cycle pulse; the upstream last_in_frame
//  in_valid     in   1     upstream bbox_valid
//  in_label     in   LW    upstream bbox_label
//  in_parent    in   LW    upstream bbox_parent
//  in_min_x/in_max_x  in  WB   box x extent
//  in_min_y/in_max_y  in  HB   box y extent
//  min_area     in   WB+HB+2  area threshold; sampled on frame_start
//  out_valid    out  1     box available
//  out_ready    in   1     downstream accepts
//  out_min_x/out_max_x out WB; out_min_y/out_max_y out HB: merged box
//  out_count    out  $clog2(MAX_OUT+1)  boxes emitted in last completed frame
//  frame_done   out  1     one-cycle pulse when emission for a frame ends
//  truncated    out  1     sticky per frame: >MAX_OUT boxes passed the filter
//  overrun      out  1     sticky until reset: frame_start arrived during EMIT
// BEHAVIOUR
//  Reset: state IDLE. All outputs are 0. All table active bits are 0.
//  Table: NUM_LABELS entries of {active, min_x, min_y, max_x, max_y}. Flop array.
//  Merge key = (in_parent != 0) ? in_parent : in_label.
//  Inputs with in_label == 0 are ignored.
//  IDLE: on frame_start, clear every active bit in one cycle, latch min_area,
//    clear the collect counter and truncated, then go to COLLECT.
//  COLLECT: the counter runs for COLLECT_CYCLES cycles. A valid input updates
//    table[key] by read-modify-write in the same cycle:
//    - if the entry is inactive, load the input box and set active;
//    - otherwise min-merge min_x/min_y and max-merge max_x/max_y.
//    The same key on back-to-back cycles must merge correctly (no hazard).
//    When the counter expires, go to EMIT with idx = 0 and emitted count = 0.
//  EMIT: scan idx 0..NUM_LABELS-1.
//    - Skip an entry in 1 cycle if it is inactive or fails the filter.
//    - Filter: area = (max_x-min_x+1)*(max_y-min_y+1), computed at full width
//      WB+HB+2 with no overflow. The box passes if area >= latched min_area.
//    - A passing box drives out_valid=1 and registered out_* fields.
//    - Hold out_valid and the fields stable until out_ready. Advance idx on the
//      cycle after the handshake. out_valid never depends on out_ready.
//    - Stop when idx wraps or when emitted == MAX_OUT.
//    - If emitted == MAX_OUT and another passing box exists, set truncated.
//    - On stop: out_count <= emitted, pulse frame_done for 1 cycle, return to IDLE.
//  frame_start during COLLECT: restart the capture (clear actives, reset counter).
//  frame_start during EMIT: abort the frame.
//    - Drop out_valid the next cycle; the pending box is discarded.
//    - Set overrun. No frame_done for the aborted frame.
//    - Then perform the IDLE frame_start actions and enter COLLECT.
//  in_valid outside COLLECT is ignored.
//  Latency: first out_valid no earlier than COLLECT_CYCLES+1 cycles after frame_start.
//  Asserting rst_n low mid-operation returns to the reset state immediately.
// TESTING
//  Single input {label 5, parent 5, box (10,20)-(19,29)}, min_area=50 -> one
//    output (10,20)-(19,29), out_count=1, frame_done pulses once.
//  Labels 7 {(0,0)-(4,4)} and 3 {(8,2)-(12,9)}, both parent 3 -> one box
//    (0,0)-(12,9).
//  Box 3x3 with min_area=10 -> no output, out_count=0, frame_done still pulses.
//  20 passing boxes, MAX_OUT=16 -> 16 outputs, then truncated=1, out_count=16.
//  out_ready held low 5 cycles on the 2nd box -> out_valid and fields stable,
//    no loss or duplication.
//  frame_start pulsed mid-EMIT -> overrun=1, no frame_done, next frame outputs
//    only its own boxes. Also: rst_n low mid-COLLECT clears everything.

Source files
------------

// File: rtl/bbox_merge_filter.sv
// Captures per-label boxes after a frame, unions them by resolved parent,
// drops boxes below a runtime area threshold and streams the survivors out.
module bbox_merge_filter #(
  parameter int WIDTH_BITS     = 11,
  parameter int HEIGHT_BITS    = 10,
  parameter int LABEL_WIDTH    = 8,
  parameter int NUM_LABELS     = 1 << LABEL_WIDTH,
  parameter int COLLECT_CYCLES = NUM_LABELS + 2,
  parameter int MAX_OUT        = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                frame_start,
  input  logic                                in_valid,
  input  logic [LABEL_WIDTH-1:0]              in_label,
  input  logic [LABEL_WIDTH-1:0]              in_parent,
  input  logic [WIDTH_BITS-1:0]               in_min_x,
  input  logic [WIDTH_BITS-1:0]               in_max_x,
  input  logic [HEIGHT_BITS-1:0]              in_min_y,
  input  logic [HEIGHT_BITS-1:0]              in_max_y,
  input  logic [WIDTH_BITS+HEIGHT_BITS+1:0]   min_area,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH_BITS-1:0]               out_min_x,
  output logic [WIDTH_BITS-1:0]               out_max_x,
  output logic [HEIGHT_BITS-1:0]              out_min_y,
  output logic [HEIGHT_BITS-1:0]              out_max_y,
  output logic [$clog2(MAX_OUT+1)-1:0]        out_count,
  output logic                                frame_done,
  output logic                                truncated,
  output logic                                overrun
);

  localparam int AW   = WIDTH_BITS + HEIGHT_BITS + 2;
  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int CNTW = $clog2(COLLECT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t state_q, state_d;

  logic [NUM_LABELS-1:0]  active;
  logic [WIDTH_BITS-1:0]  tbl_min_x [NUM_LABELS];
  logic [WIDTH_BITS-1:0]  tbl_max_x [NUM_LABELS];
  logic [HEIGHT_BITS-1:0] tbl_min_y [NUM_LABELS];
  logic [HEIGHT_BITS-1:0] tbl_max_y [NUM_LABELS];

  logic [AW-1:0]          min_area_q;
  logic [CNTW-1:0]        cnt_q;
  logic [LABEL_WIDTH-1:0] idx_q;
  logic [CW-1:0]          emitted_q;

  logic [LABEL_WIDTH-1:0] key;
  logic [AW-1:0]          dx, dy, area;
  logic                   scan_pass, idx_last;
  logic                   do_start, ins_we, hs, load, adv, stop, trunc_set, ovr_set;

  assign key      = (in_parent != '0) ? in_parent : in_label;
  assign dx       = AW'(tbl_max_x[idx_q]) - AW'(tbl_min_x[idx_q]) + AW'(1);
  assign dy       = AW'(tbl_max_y[idx_q]) - AW'(tbl_min_y[idx_q]) + AW'(1);
  assign area     = dx * dy;
  assign scan_pass = active[idx_q] && (area >= min_area_q);
  assign idx_last = (idx_q == LABEL_WIDTH'(NUM_LABELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A truncation decision needs one more passing box, so the scan continues
  // past MAX_OUT emissions until it finds one or reaches the last index.
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    ins_we    = 1'b0;
    hs        = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    stop      = 1'b0;
    trunc_set = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          do_start = 1'b1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          do_start = 1'b1;
        end else begin
          ins_we = in_valid && (in_label != '0);
          if (cnt_q == CNTW'(COLLECT_CYCLES - 1)) state_d = EMIT;
        end
      end
      EMIT: begin
        if (frame_start) begin
          do_start = 1'b1;
          ovr_set  = 1'b1;
          state_d  = COLLECT;
        end else if (out_valid) begin
          if (out_ready) begin
            hs  = 1'b1;
            adv = 1'b1;
            if (idx_last) stop = 1'b1;
          end
        end else if (scan_pass) begin
          if (emitted_q == CW'(MAX_OUT)) begin
            trunc_set = 1'b1;
            stop      = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else begin
          adv = 1'b1;
          if (idx_last) stop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      min_area_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      emitted_q  <= '0;
      out_valid  <= 1'b0;
      out_min_x  <= '0;
      out_max_x  <= '0;
      out_min_y  <= '0;
      out_max_y  <= '0;
      out_count  <= '0;
      frame_done <= 1'b0;
      truncated  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= stop;
      if (do_start) begin
        active     <= '0;
        min_area_q <= min_area;
        cnt_q      <= '0;
        idx_q      <= '0;
        emitted_q  <= '0;
        truncated  <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        if (ins_we) active[key] <= 1'b1;
        if (state_q == COLLECT) cnt_q <= cnt_q + CNTW'(1);
        if (adv) idx_q <= idx_q + LABEL_WIDTH'(1);
        if (hs) begin
          out_valid <= 1'b0;
          emitted_q <= emitted_q + CW'(1);
        end
        if (load) begin
          out_valid <= 1'b1;
          out_min_x <= tbl_min_x[idx_q];
          out_max_x <= tbl_max_x[idx_q];
          out_min_y <= tbl_min_y[idx_q];
          out_max_y <= tbl_max_y[idx_q];
        end
        if (trunc_set) truncated <= 1'b1;
        if (stop) out_count <= hs ? emitted_q + CW'(1) : emitted_q;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

  // Coordinates are qualified by the active bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (ins_we) begin
      if (!active[key]) begin
        tbl_min_x[key] <= in_min_x;
        tbl_max_x[key] <= in_max_x;
        tbl_min_y[key] <= in_min_y;
        tbl_max_y[key] <= in_max_y;
      end else begin
        if (in_min_x < tbl_min_x[key]) tbl_min_x[key] <= in_min_x;
        if (in_max_x > tbl_max_x[key]) tbl_max_x[key] <= in_max_x;
        if (in_min_y < tbl_min_y[key]) tbl_min_y[key] <= in_min_y;
        if (in_max_y > tbl_max_y[key]) tbl_max_y[key] <= in_max_y;
      end
    end
  end

endmodule
